// File: rtl/mlp_pkg.sv
// mlp_pkg: shared FSM state type, datapath widths and address-width helper
// for the MLP layer blocks.
package mlp_pkg;
    localparam int ACT_W  = 16;
    localparam int WGT_W  = 8;
    localparam int BIAS_W = 8;

    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t STREAM = 2'd1;
    localparam state_t DRAIN  = 2'd2;
    localparam state_t WRITE  = 2'd3;

    // Never returns 0, so single-entry memories still get a 1-bit address.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/relu16.sv
// relu16: combinational ReLU on a 16-bit signed value, bypassed when en is low.
module relu16
    import mlp_pkg::*;
(
    input  logic                    en,
    input  logic signed [ACT_W-1:0] a,
    output logic signed [ACT_W-1:0] y
);
    assign y = (en && a[ACT_W-1]) ? '0 : a;
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: streams activations/weights/bias of one dense layer into an
// external MAC, one neuron at a time, and writes back each (optionally ReLU'd) result.
module layer_sequencer
    import mlp_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int N_OUT = 8,
    parameter int RELU  = 1,
    localparam int IW = clog2(N_IN),
    localparam int WW = clog2(N_IN * N_OUT),
    localparam int JW = clog2(N_OUT)
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [IW-1:0]            act_addr,
    input  logic signed [ACT_W-1:0]  act_rdata,
    output logic [WW-1:0]            w_addr,
    input  logic signed [WGT_W-1:0]  w_rdata,
    output logic [JW-1:0]            b_addr,
    input  logic signed [BIAS_W-1:0] b_rdata,
    output logic                     mac_first,
    output logic signed [ACT_W-1:0]  mac_op1,
    output logic signed [WGT_W-1:0]  mac_op2,
    output logic signed [BIAS_W-1:0] mac_bias,
    input  logic signed [ACT_W-1:0]  mac_out,
    output logic                     res_we,
    output logic [JW-1:0]            res_addr,
    output logic signed [ACT_W-1:0]  res_data
);
    state_t state;
    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic valid_d, first_d, last_i, last_j;
    logic signed [BIAS_W-1:0] bias_q;
    logic signed [ACT_W-1:0] relu_out;

    assign last_i = i == IW'(N_IN - 1);
    assign last_j = j == JW'(N_OUT - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            i       <= '0;
            j       <= '0;
            done    <= 1'b0;
            valid_d <= 1'b0;
            first_d <= 1'b0;
            bias_q  <= '0;
        end else begin
            done    <= state == WRITE && last_j;
            // Read data lags the address by one cycle; these flags travel with it.
            valid_d <= state == STREAM;
            first_d <= state == STREAM && i == '0;
            if (first_d) bias_q <= b_rdata;
            case (state)
                IDLE:    if (start && !done) state <= STREAM;
                STREAM: begin
                    i <= last_i ? '0 : i + 1'b1;
                    if (last_i) state <= DRAIN;
                end
                DRAIN:   state <= WRITE;
                default: begin
                    j     <= last_j ? '0 : j + 1'b1;
                    state <= last_j ? IDLE : STREAM;
                end
            endcase
        end
    end

    assign busy      = state != IDLE;
    assign act_addr  = i;
    assign w_addr    = WW'(j) * WW'(N_IN) + WW'(i);
    assign b_addr    = j;
    assign mac_first = first_d;
    // The MAC accumulates every clock, so idle cycles must feed a zero product.
    assign mac_op1   = valid_d ? act_rdata : '0;
    assign mac_op2   = valid_d ? w_rdata : '0;
    assign mac_bias  = first_d ? b_rdata : bias_q;
    assign res_we    = state == WRITE;
    assign res_addr  = j;
    assign res_data  = res_we ? relu_out : '0;

    relu16 u_relu (
        .en (RELU != 0),
        .a  (mac_out),
        .y  (relu_out)
    );
endmodule
